// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer that time-shares one iterative multiplier between NUM_REQ
// clients: accept one operand pair, pulse start, wait for done (or watchdog), respond.
module mul_share_arbiter #(
    parameter int N       = 64,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*N-1:0]         req_a,
    input  logic [NUM_REQ*N-1:0]         req_b,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [N-1:0]                 resp_product,
    output logic                         resp_err,
    output logic                         mul_start,
    output logic [N-1:0]                 mul_multiplicand,
    output logic [N-1:0]                 mul_multiplier,
    input  logic [N-1:0]                 mul_product,
    input  logic                         mul_done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [N-1:0]   prod_q, prod_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           win_found;
    logic [IDW-1:0] win_idx;

    // Cyclic search starting just after the last owner.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        a_d        = a_q;
        b_d        = b_q;
        prod_d     = prod_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        resp_valid = '0;
        mul_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    last_d  = win_idx;
                    grant_d = win_idx;
                    a_d     = req_a[int'(win_idx)*N +: N];
                    b_d     = req_b[int'(win_idx)*N +: N];
                    state_d = START;
                end
            end
            START: begin
                mul_start = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // done takes priority over an expiring watchdog
                if (mul_done) begin
                    prod_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                resp_valid[grant_q] = 1'b1;
                if (resp_ready[grant_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Keep the combinational accept quiet while reset is held.
        if (rst) req_ready = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDW'(NUM_REQ-1);
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy             = (state_q != IDLE);
    assign grant_id         = grant_q;
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign resp_product     = prod_q;
    assign resp_err         = err_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a stub multiplier (fixed latency, optional hang).
module tb_mul_share_arbiter;

    localparam int N  = 64;
    localparam int NR = 4;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [NR*N-1:0] req_a, req_b;
    logic [N-1:0]    resp_product, mul_multiplicand, mul_multiplier, mul_product;
    logic            resp_err, mul_start, mul_done, busy;
    logic [1:0]      grant_id;

    logic            hang;
    int              mcnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.N(N), .NUM_REQ(NR), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_product(resp_product), .resp_err(resp_err),
        .mul_start(mul_start),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_product(mul_product), .mul_done(mul_done),
        .busy(busy), .grant_id(grant_id)
    );

    // Stub multiplier: done pulses LAT+1 cycles after the start edge unless hung.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt        <= 0;
            mul_done    <= 1'b0;
            mul_product <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_start) begin
                mcnt <= LAT;
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1 && !hang) begin
                    mul_done    <= 1'b1;
                    mul_product <= mul_multiplicand * mul_multiplier;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 40 && resp_valid == '0; i++) tick();
    endtask

    task automatic set_ops(input int c, input logic [63:0] a, input logic [63:0] b);
        req_a[c*N +: N] = a;
        req_b[c*N +: N] = b;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rdy"},   64'(req_ready), 0);
        chk({tag, ".rv"},    64'(resp_valid), 0);
        chk({tag, ".prod"},  resp_product, 0);
        chk({tag, ".err"},   64'(resp_err), 0);
        chk({tag, ".start"}, 64'(mul_start), 0);
        chk({tag, ".ma"},    mul_multiplicand, 0);
        chk({tag, ".mb"},    mul_multiplier, 0);
        chk({tag, ".busy"},  64'(busy), 0);
        chk({tag, ".gid"},   64'(grant_id), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
    endtask

    // One complete operation from a single requesting client.
    task automatic do_op(input string tag, input int c, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] ep, input logic ee);
        logic [NR-1:0] oh;
        oh = '0;
        oh[c] = 1'b1;
        set_ops(c, a, b);
        req_valid[c] = 1'b1;
        #1;
        chk({tag, ".ready"}, 64'(req_ready), 64'(oh));
        tick();
        req_valid[c] = 1'b0;
        chk({tag, ".start"}, 64'(mul_start), 1);
        chk({tag, ".gid"}, 64'(grant_id), 64'(c));
        wait_resp();
        chk({tag, ".rv"}, 64'(resp_valid), 64'(oh));
        chk({tag, ".prod"}, resp_product, ep);
        chk({tag, ".err"}, 64'(resp_err), 64'(ee));
        resp_ready[c] = 1'b1;
        tick();
        resp_ready[c] = 1'b0;
        chk({tag, ".idle"}, 64'(busy), 0);
    endtask

    initial begin
        logic [NR-1:0] oh;
        int            multi;
        int            cyc;
        rst = 1'b1; hang = 1'b0;
        req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
        #2;
        do_reset();

        // Single client
        do_op("single", 0, 64'd11, 64'd14, 64'd154, 1'b0);

        // Full contention from reset: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NR; i++) set_ops(i, 64'(i+1), -64'sd3);
        req_valid = '1;
        multi = 0;
        for (int op = 0; op < 5; op++) begin
            oh = '0;
            oh[op % NR] = 1'b1;
            #1;
            chk($sformatf("cont%0d.ready", op), 64'(req_ready), 64'(oh));
            tick();
            for (int i = 0; i < 40 && resp_valid == '0; i++) begin
                if ($countones(resp_valid) > 1) multi++;
                tick();
            end
            chk($sformatf("cont%0d.rv", op), 64'(resp_valid), 64'(oh));
            chk($sformatf("cont%0d.prod", op), resp_product, 64'(-3*((op % NR)+1)));
            resp_ready = '1;
            tick();
            resp_ready = '0;
        end
        req_valid = '0;
        chk("cont.onehot", 64'(multi), 0);

        // Edge operands through client 2
        do_op("edge1", 2, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 1'b0);
        do_op("edge2", 2, 64'h7FFF_FFFF_FFFF_FFFF, -64'sd1, 64'h8000_0000_0000_0001, 1'b0);
        do_op("edge3", 2, -64'sd987654321, 64'sd123456789, -64'sd121932631112635269, 1'b0);

        // Backpressure: client 1 stalls its response while client 3 waits
        set_ops(1, 64'd6, 64'd7);
        set_ops(3, 64'd2, 64'd3);
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1;
        wait_resp();
        chk("bp.rv", 64'(resp_valid), 64'b0010);
        resp_ready = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.prod", i), resp_product, 64'd42);
            chk($sformatf("bp%0d.rdy", i), 64'(req_ready), 0);
            tick();
        end
        chk("bp.hold", 64'(resp_valid), 64'b0010);
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        chk("bp.accept3", 64'(req_ready), 64'b1000);
        tick();
        req_valid[3] = 1'b0;
        chk("bp.gid3", 64'(grant_id), 3);
        wait_resp();
        chk("bp.rv3", 64'(resp_valid), 64'b1000);
        chk("bp.prod3", resp_product, 64'd6);
        resp_ready[3] = 1'b1;
        tick();
        resp_ready = '0;

        // Watchdog
        hang = 1'b1;
        set_ops(0, 64'd3, 64'd3);
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        tick();
        cyc = 0;
        while (resp_valid == '0 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("wd.cycles", 64'(cyc), 8);
        chk("wd.err", 64'(resp_err), 1);
        chk("wd.prod", resp_product, 0);
        resp_ready[0] = 1'b1;
        tick();
        resp_ready = '0;
        hang = 1'b0;
        do_op("wd.after", 0, 64'd5, 64'd5, 64'd25, 1'b0);

        // Asynchronous reset in the middle of WAIT
        set_ops(1, 64'd9, 64'd9);
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        req_valid = 4'b0011;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("arst");
        tick();
        tick();
        chk("arst.norv", 64'(resp_valid), 0);
        rst = 1'b0;
        #1;
        chk("arst.win0", 64'(req_ready), 64'b0001);
        set_ops(0, 64'd3, 64'd4);
        tick();
        req_valid = '0;
        wait_resp();
        chk("arst.rv", 64'(resp_valid), 64'b0001);
        chk("arst.prod", resp_product, 64'd12);
        resp_ready[0] = 1'b1;
        tick();
        resp_ready = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
